// File: rtl/adc_scan_sequencer.sv
// Automatic chip-select scheduler for the ADC bank: walks the enabled ADCs in
// ascending order, holding each select low for CS_HOLD clocks with a CS_GAP gap.
module adc_scan_sequencer #(
  parameter int N_ADC   = 18,
  parameter int CS_HOLD = 32,
  parameter int CS_GAP  = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             cmd_valid,
  input  logic [7:0]       cmd_byte,
  input  logic [7:0]       data_byte,
  output logic [N_ADC-1:0] adc_ncs,
  output logic             scan_busy,
  output logic [4:0]       cur_adc,
  output logic             conv_done,
  output logic             frame_done,
  output logic [N_ADC-1:0] enable_mask
);

  localparam int CNT_MAX = (CS_HOLD > CS_GAP) ? CS_HOLD : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [N_ADC-1:0] ONE = N_ADC'(1);

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_GAP, S_ADVANCE} state_e;
  typedef enum logic {MODE_SINGLE, MODE_CONT} mode_e;

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [4:0]       cur_q, cur_d;
  logic             stop_q, stop_d;
  logic [N_ADC-1:0] mask_q, mask_d;
  logic [N_ADC-1:0] ncs_q, ncs_d;
  logic             conv_q, conv_d;
  logic             frame_q, frame_d;

  logic             idx_ok, cmd_set, cmd_clr, cmd_single, cmd_cont, cmd_stop;
  logic             start_ok, hold_end, gap_end;
  logic [N_ADC-1:0] mask_bit;
  logic [4:0]       lowest_idx, next_idx;
  logic             lowest_found, next_found;

  assign idx_ok     = (data_byte < 8'(N_ADC));
  assign mask_bit   = ONE << data_byte[4:0];
  assign cmd_set    = cmd_valid && (cmd_byte == 8'h61) && idx_ok;
  assign cmd_clr    = cmd_valid && (cmd_byte == 8'h62) && idx_ok;
  assign cmd_single = cmd_valid && (cmd_byte == 8'h63);
  assign cmd_cont   = cmd_valid && (cmd_byte == 8'h64);
  assign cmd_stop   = cmd_valid && (cmd_byte == 8'h65);
  assign start_ok   = (cmd_single || cmd_cont) && (mask_q != '0);
  assign hold_end   = (cnt_q == CW'(CS_HOLD - 1));
  assign gap_end    = (cnt_q == CW'(CS_GAP - 1));

  // Descending scan so the last hit is the lowest qualifying index.
  always_comb begin
    lowest_idx   = '0;
    lowest_found = 1'b0;
    next_idx     = '0;
    next_found   = 1'b0;
    for (int i = N_ADC - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        lowest_idx   = 5'(i);
        lowest_found = 1'b1;
        if (i > int'(cur_q)) begin
          next_idx   = 5'(i);
          next_found = 1'b1;
        end
      end
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (cmd_set) mask_d = mask_q | mask_bit;
    if (cmd_clr) mask_d = mask_q & ~mask_bit;
  end

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    cur_d   = cur_q;
    stop_d  = stop_q;
    if (cmd_stop && (state_q != S_IDLE)) stop_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        stop_d = 1'b0;
        if (start_ok) begin
          mode_d  = cmd_cont ? MODE_CONT : MODE_SINGLE;
          cur_d   = lowest_idx;
          state_d = S_SELECT;
        end
      end
      S_SELECT: begin
        cnt_d = hold_end ? '0 : cnt_q + 1'b1;
        if (hold_end) state_d = S_GAP;
      end
      S_GAP: begin
        cnt_d = gap_end ? '0 : cnt_q + 1'b1;
        if (gap_end) state_d = S_ADVANCE;
      end
      default: begin
        cnt_d = '0;
        if (stop_q || cmd_stop) begin
          stop_d  = 1'b0;
          state_d = S_IDLE;
        end else if (next_found) begin
          cur_d   = next_idx;
          state_d = S_SELECT;
        end else if ((mode_q == MODE_SINGLE) || !lowest_found) begin
          state_d = S_IDLE;
        end else begin
          cur_d   = lowest_idx;
          state_d = S_SELECT;
        end
      end
    endcase
  end

  // Outputs are registered from the current state, so a select trails SELECT by one clock.
  always_comb begin
    ncs_d   = '1;
    conv_d  = 1'b0;
    frame_d = 1'b0;
    if (state_q == S_SELECT) begin
      ncs_d = ~(ONE << cur_q);
      if (hold_end) begin
        conv_d  = 1'b1;
        frame_d = !next_found;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the async reset also
  // releases the chip selects immediately, without waiting for a clock edge.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_IDLE;
      mode_q  <= MODE_SINGLE;
      cnt_q   <= '0;
      cur_q   <= '0;
      stop_q  <= 1'b0;
      mask_q  <= '0;
      ncs_q   <= '1;
      conv_q  <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      cur_q   <= cur_d;
      stop_q  <= stop_d;
      mask_q  <= mask_d;
      ncs_q   <= ncs_d;
      conv_q  <= conv_d;
      frame_q <= frame_d;
    end
  end

  assign adc_ncs     = ncs_q;
  assign scan_busy   = (state_q != S_IDLE);
  assign cur_adc     = cur_q;
  assign conv_done   = conv_q;
  assign frame_done  = frame_q;
  assign enable_mask = mask_q;

endmodule

// File: tb/tb_adc_scan_sequencer.sv
// Scoreboard bench for adc_scan_sequencer: expected conversions are queued as
// each scan is launched and retired by a monitor on every conv_done pulse.
module tb_adc_scan_sequencer;

  localparam int N_ADC   = 18;
  localparam int CS_HOLD = 32;
  localparam int CS_GAP  = 4;

  typedef struct {
    logic [4:0] idx;
    logic       last;
  } exp_t;

  logic             clk = 1'b0;
  logic             nrst = 1'b0;
  logic             cmd_valid = 1'b0;
  logic [7:0]       cmd_byte = '0;
  logic [7:0]       data_byte = '0;
  logic [N_ADC-1:0] adc_ncs;
  logic             scan_busy;
  logic [4:0]       cur_adc;
  logic             conv_done;
  logic             frame_done;
  logic [N_ADC-1:0] enable_mask;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   conv_cnt = 0;
  int   frame_cnt = 0;

  int   low_idx = 0;
  int   low_cnt = 0;
  bit   was_low = 0;
  int   gap_cnt = 0;
  bit   gap_valid = 0;

  adc_scan_sequencer #(.N_ADC(N_ADC), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP)) dut (
    .clk(clk), .nrst(nrst), .cmd_valid(cmd_valid), .cmd_byte(cmd_byte),
    .data_byte(data_byte), .adc_ncs(adc_ncs), .scan_busy(scan_busy),
    .cur_adc(cur_adc), .conv_done(conv_done), .frame_done(frame_done),
    .enable_mask(enable_mask)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int low_index(input logic [N_ADC-1:0] ncs);
    int r = -1;
    for (int i = 0; i < N_ADC; i++) if (!ncs[i]) r = i;
    return r;
  endfunction

  // Monitor: chip-select invariant, hold/gap lengths, scoreboard retirement.
  always @(negedge clk) begin
    if (!nrst) begin
      was_low   = 0;
      low_cnt   = 0;
      gap_cnt   = 0;
      gap_valid = 0;
    end else begin
      check("cs_onehot", 32'($countones(~adc_ncs) <= 1), 1);
      check("frame_without_conv", 32'(frame_done & ~conv_done), 0);
      if (adc_ncs != '1) begin
        if (!was_low) begin
          if (gap_valid) check("gap_len", gap_cnt, CS_GAP + 1);
          low_idx = low_index(adc_ncs);
          low_cnt = 0;
        end else begin
          check("cs_idx_stable", low_index(adc_ncs), low_idx);
        end
        low_cnt++;
        was_low = 1;
      end else begin
        if (was_low) begin
          check("hold_len", low_cnt, CS_HOLD);
          gap_cnt   = 1;
          gap_valid = 1;
        end else begin
          gap_cnt++;
        end
        was_low = 0;
        if (!scan_busy) gap_valid = 0;
      end
      if (conv_done) begin
        exp_t e;
        conv_cnt++;
        if (frame_done) frame_cnt++;
        check("sb_nonempty", 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          check("conv_cur_adc", cur_adc, e.idx);
          check("conv_cs_idx", low_idx, e.idx);
          check("conv_hold_at_done", low_cnt, CS_HOLD);
          check("frame_done", frame_done, e.last);
        end
      end
    end
  end

  task automatic send_cmd(input logic [7:0] c, input logic [7:0] d);
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_byte  = c;
    data_byte = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (scan_busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", scan_busy, 0);
  endtask

  task automatic wait_cs_low(input int idx, input int budget);
    int n = 0;
    while (adc_ncs[idx] && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("cs_low_timeout", adc_ncs[idx], 0);
  endtask

  task automatic wait_conv(input int budget);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!conv_done && n < budget);
    check("conv_timeout", conv_done, 1);
  endtask

  task automatic push(input int idx, input bit last);
    exp_t e;
    e.idx  = 5'(idx);
    e.last = last;
    sb_q.push_back(e);
  endtask

  initial begin
    int base_conv, base_frame, n;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_conv, base_frame, n;

    // Reset values, then a single frame over {0,5,17}.
    do_reset();
    check("rst_ncs", adc_ncs, {N_ADC{1'b1}});
    check("rst_mask", enable_mask, 0);
    check("rst_busy", scan_busy, 0);
    check("rst_cur", cur_adc, 0);
    check("rst_conv", conv_done, 0);
    check("rst_frame", frame_done, 0);
    send_cmd(8'h61, 8'd0);
    check("mask_set0", enable_mask, 32'h1);
    send_cmd(8'h61, 8'd5);
    send_cmd(8'h61, 8'd17);
    check("mask_0_5_17", enable_mask, 32'h20021);
    base_conv = conv_cnt; base_frame = frame_cnt;
    push(0, 0); push(5, 0); push(17, 1);
    send_cmd(8'h63, 8'd0);
    check("start_busy", scan_busy, 1);
    check("start_ncs_still_high", adc_ncs, {N_ADC{1'b1}});
    @(negedge clk);
    check("first_select", adc_ncs, ~32'h1 & {N_ADC{1'b1}});
    wait_idle(500);
    @(negedge clk); #1;
    check("s1_conv_count", conv_cnt - base_conv, 3);
    check("s1_frame_count", frame_cnt - base_frame, 1);
    check("s1_sb_empty", sb_q.size(), 0);
    check("s1_idle_ncs", adc_ncs, {N_ADC{1'b1}});

    // Continuous over {3}, stop during the 2nd frame's select.
    do_reset();
    send_cmd(8'h61, 8'd3);
    base_conv = conv_cnt;
    push(3, 1); push(3, 1);
    send_cmd(8'h64, 8'd0);
    wait_conv(200);
    wait_cs_low(3, 50);
    repeat (10) @(negedge clk);
    send_cmd(8'h65, 8'd0);
    check("stop_still_selected", adc_ncs[3], 0);
    wait_conv(200);
    n = 0;
    while (scan_busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("stop_idle_latency", n, CS_GAP + 1);
    @(negedge clk); #1;
    check("s2_conv_count", conv_cnt - base_conv, 2);
    check("s2_sb_empty", sb_q.size(), 0);

    // Ignored commands: start with empty mask, out-of-range index, start while busy.
    do_reset();
    send_cmd(8'h63, 8'd0);
    repeat (3) @(negedge clk);
    check("empty_start_busy", scan_busy, 0);
    check("empty_start_ncs", adc_ncs, {N_ADC{1'b1}});
    send_cmd(8'h61, 8'd18);
    check("mask_idx18", enable_mask, 0);
    send_cmd(8'h61, 8'd200);
    check("mask_idx200", enable_mask, 0);
    send_cmd(8'h61, 8'd1);
    send_cmd(8'h61, 8'd4);
    send_cmd(8'h62, 8'd18);
    check("mask_clr18", enable_mask, 32'h12);
    send_cmd(8'h65, 8'd0);
    base_conv = conv_cnt;
    push(1, 0); push(4, 1);
    send_cmd(8'h63, 8'd0);
    repeat (5) @(negedge clk);
    send_cmd(8'h64, 8'd0);
    send_cmd(8'h63, 8'd0);
    wait_idle(500);
    repeat (5) @(negedge clk); #1;
    check("s3_conv_count", conv_cnt - base_conv, 2);
    check("s3_sb_empty", sb_q.size(), 0);
    check("s3_idle", scan_busy, 0);

    // Continuous over {2,9}; drop 9 during 2's hold so each frame is just 2.
    do_reset();
    send_cmd(8'h61, 8'd2);
    send_cmd(8'h61, 8'd9);
    base_conv = conv_cnt; base_frame = frame_cnt;
    push(2, 1); push(2, 1);
    send_cmd(8'h64, 8'd0);
    wait_cs_low(2, 50);
    repeat (5) @(negedge clk);
    send_cmd(8'h62, 8'd9);
    check("mask_drop9", enable_mask, 32'h4);
    wait_conv(200);
    @(negedge clk);
    wait_cs_low(2, 50);
    check("wrap_cur", cur_adc, 2);
    send_cmd(8'h65, 8'd0);
    wait_idle(500);
    @(negedge clk); #1;
    check("s4_conv_count", conv_cnt - base_conv, 2);
    check("s4_frame_count", frame_cnt - base_frame, 2);
    check("s4_sb_empty", sb_q.size(), 0);

    // Asynchronous reset in the middle of a select.
    do_reset();
    send_cmd(8'h61, 8'd7);
    base_conv = conv_cnt;
    send_cmd(8'h63, 8'd0);
    wait_cs_low(7, 50);
    repeat (10) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    check("async_ncs", adc_ncs, {N_ADC{1'b1}});
    check("async_mask", enable_mask, 0);
    check("async_busy", scan_busy, 0);
    repeat (2) @(negedge clk);
    #1 nrst = 1'b1;
    repeat (40) @(negedge clk);
    #1;
    check("post_rst_busy", scan_busy, 0);
    check("post_rst_ncs", adc_ncs, {N_ADC{1'b1}});
    check("post_rst_conv", conv_cnt - base_conv, 0);
    check("final_sb_empty", sb_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/adc_scan_sequencer.md
# adc_scan_sequencer

Clocked scheduler that owns the 18 active-low ADC chip selects and sequences them automatically. It asserts each enabled ADC's chip select in ascending index order for a fixed hold window, separated by a guard gap, in single-frame or continuous mode. It sits behind the SPI command decoder and consumes already-split command/data bytes from a 16-bit command word. Whenever the sequencer is running, it replaces static chip-select control.

## Interface
- N_ADC, 18, number of ADC chip selects (1..32)
- CS_HOLD, 32, clocks each chip select is held low per conversion (≥1)
- CS_GAP, 4, clocks all chip selects are held high between conversions (≥1)

- clk  in  1  system clock, all logic on rising edge
- nrst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  one-cycle strobe; cmd_byte/data_byte valid this cycle
- cmd_byte  in  8  command code (ASCII)
- data_byte  in  8  argument, ADC index for mask commands
- adc_ncs  out  N_ADC  registered chip selects, active low
- scan_busy  out  1  high in any state other than IDLE
- cur_adc  out  5  index currently or last selected
- conv_done  out  1  one-cycle pulse at end of each hold window
- frame_done  out  1  one-cycle pulse at end of last conversion of a frame
- enable_mask  out  N_ADC  current enable mask, readable for status reporting

## Operation
- Commands, decoded only when cmd_valid=1, unknown codes ignored:
  - "a" (0x61): set enable_mask[data_byte]
  - "b" (0x62): clear enable_mask[data_byte]
  - "c" (0x63): start single frame
  - "d" (0x64): start continuous
  - "e" (0x65): stop
- Mask commands with data_byte ≥ N_ADC are ignored. Mask commands are accepted in every state; a change takes effect at the next ADVANCE, and the current conversion is never cut short.
- Start commands ("c"/"d") are accepted only in IDLE with enable_mask ≠ 0; otherwise they are ignored. A start while busy is ignored and the mode does not change.
- FSM states:
  - IDLE: all adc_ncs high, counters cleared. On a valid start, latch the mode and cur_adc ← lowest enabled index, then go to SELECT.
  - SELECT: adc_ncs[cur_adc]=0, all other bits 1. Hold for CS_HOLD cycles, then go to GAP and pulse conv_done.
  - GAP: all adc_ncs high for CS_GAP cycles, then go to ADVANCE.
  - ADVANCE (1 cycle, all high): take the next enabled index above cur_adc and go to SELECT. If none remains, the frame ends:
    - If stop is pending, or mode is single, or the mask is now 0: go to IDLE.
    - Otherwise (continuous): wrap to the lowest enabled index and go to SELECT.
- frame_done pulses together with conv_done for the highest enabled index of the frame, using the mask as sampled at that conv_done.
- "e" sets stop_pending. The current SELECT/GAP completes, then the block goes to IDLE at ADVANCE; stop_pending clears there. "e" in IDLE has no effect.
- Invariant: at most one adc_ncs bit is low in any cycle.
- Counter width is $clog2(max(CS_HOLD,CS_GAP)+1); the counter never wraps.

## Timing
- Reset (async, nrst=0):
  - adc_ncs all 1, enable_mask 0, scan_busy 0, cur_adc 0, conv_done 0, frame_done 0
  - mode single, stop_pending 0, state IDLE
  - A reset mid-SELECT releases the chip select immediately, without waiting for a clock edge.
- A start accepted on edge k drives adc_ncs low from edge k+1.
- The chip select is low for exactly CS_HOLD cycles.
- conv_done is high in the first GAP cycle.
- Conversion-to-conversion period is CS_HOLD+CS_GAP+1 cycles.
- Mask updates are visible on enable_mask one cycle after cmd_valid.
- A stop and a mask command in the same cycle cannot occur, since there is one command per strobe.

## Test plan
- Reset, then mask {0,5,17}, then "c": adc_ncs bit 0, then bit 5, then bit 17 each go low for 32 cycles, with 5 high cycles between them. conv_done fires 3 times, frame_done fires once with the third conv_done, then IDLE with scan_busy 0.
- Mask {3}, then "d", then "e" mid-SELECT of the 2nd frame: that conversion completes its full 32 cycles, and IDLE is reached after its GAP+ADVANCE. Exactly 2 conv_done pulses.
- "c" with mask 0, "a" with data_byte 18, and "c" issued while busy: no state change in any case, and adc_ncs stays all 1 or continues unchanged.
- Continuous mode with mask {2,9}: during ADC 2's hold, send "b" with data_byte 9. After 2 the frame ends and wraps to 2; frame_done fires on 2's conv_done.
- Assert nrst low mid-SELECT: adc_ncs goes all 1 asynchronously and enable_mask goes 0. After release, the block stays IDLE until a new start.
- Every cycle of every scenario: check that popcount(~adc_ncs) ≤ 1.
